digit_serial_adder: RTL and testbench

- Multi-cycle, parametrised WIDTH-bit adder: S = A + B + Cin, computed DIGIT bits per clock over WIDTH/DIGIT cycles.
- Each digit step is a DIGIT-bit ripple-carry add; the carry is held in a register between digits.
- Trades latency for area against the single-cycle ripple adders.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths.

---
 rtl/digit_serial_adder.sv | 126 ++++++++++++
 tb/tb_digit_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: computes S = A + B + Cin over WIDTH/DIGIT clock cycles,
// adding DIGIT bits per cycle. A carry register links one digit to the next.
// Valid/ready handshakes on both sides: an operation is accepted in IDLE,
// its digits are added in RUN, and the result is held in DONE until it is taken.
// Optional feature macro: DIGIT_SERIAL_OVF_EN adds the signed-overflow output V.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef DIGIT_SERIAL_OVF_EN
    output logic             C,
    output logic             V
`else
    output logic             C
`endif
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [CNT_W-1:0]   counter;
    int                 base;
    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [DIGIT:0]     digit_sum;
    logic               last_digit;
    logic               accept;

    // Handshake outputs depend only on the registered state; reset blocks intake.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Slice out the digit currently being processed.
    assign base       = int'(counter) * DIGIT;
    assign a_dig      = a_reg[base +: DIGIT];
    assign b_dig      = b_reg[base +: DIGIT];
    assign last_digit = (counter == CNT_W'(NUM_DIGITS - 1));

    // One DIGIT-bit ripple add per cycle, carry-in taken from the carry register.
    always_comb begin
        digit_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, leave RUN after the last digit, leave DONE on handoff.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = RUN;
            RUN:     if (last_digit) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, build the sum digit by digit in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            S       <= '0;
            C       <= 1'b0;
            carry   <= 1'b0;
            counter <= '0;
`ifdef DIGIT_SERIAL_OVF_EN
            V       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        carry   <= Cin;
                        counter <= '0;
                        S       <= '0;
                    end
                end
                RUN: begin
                    S[base +: DIGIT] <= digit_sum[DIGIT-1:0];
                    carry            <= digit_sum[DIGIT];
                    if (last_digit) begin
                        C <= digit_sum[DIGIT];
`ifdef DIGIT_SERIAL_OVF_EN
                        V <= (a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ digit_sum[DIGIT-1])
                             ^ digit_sum[DIGIT];
`endif
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors for a 16-bit adder with 4-bit digits and
// a second instance with a single 16-bit digit. Expected results are pushed into
// per-instance queues and popped by monitors whenever a result is handed off.
module tb_digit_serial_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, c4;
    logic [15:0] a4, b4, s4;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, c16;
    logic [15:0] a16, b16, s16;
`ifdef DIGIT_SERIAL_OVF_EN
    logic        v4, v16;
`endif

    exp_t sb4[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .Cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .S(s4),
`ifdef DIGIT_SERIAL_OVF_EN
        .C(c4), .V(v4)
`else
        .C(c4)
`endif
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .Cin(cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .S(s16),
`ifdef DIGIT_SERIAL_OVF_EN
        .C(c16), .V(v16)
`else
        .C(c16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor for the 4-bit-digit instance: pop and compare on every handoff.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) begin
            if (sb4.size() == 0) begin
                checkOutput("d4_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                checkOutput("d4_sum", {16'd0, s4}, {16'd0, e.s});
                checkOutput("d4_carry", {31'd0, c4}, {31'd0, e.c});
`ifdef DIGIT_SERIAL_OVF_EN
                checkOutput("d4_ovf", {31'd0, v4}, {31'd0, e.v});
`endif
            end
        end
    end

    // Monitor for the single-digit instance.
    always @(negedge clk) begin
        if (!rst && out_valid16 && out_ready16) begin
            if (sb16.size() == 0) begin
                checkOutput("d16_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                checkOutput("d16_sum", {16'd0, s16}, {16'd0, e.s});
                checkOutput("d16_carry", {31'd0, c16}, {31'd0, e.c});
`ifdef DIGIT_SERIAL_OVF_EN
                checkOutput("d16_ovf", {31'd0, v16}, {31'd0, e.v});
`endif
            end
        end
    end

    // One operation on the 4-bit-digit instance. corrupt wiggles inputs during RUN;
    // hold keeps out_ready low for that many cycles in DONE.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [15:0] es, input logic ec, input logic ev,
                                 input bit corrupt, input int hold);
        int lat;
        int guard;
        exp_t e;
        guard = 0;
        while (!in_ready4 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("d4_ready_before_accept", {31'd0, in_ready4}, 32'd1);
        e.s = es; e.c = ec; e.v = ev;
        sb4.push_back(e);
        out_ready4 = (hold == 0);
        a4 = a; b4 = b; cin4 = cin; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        if (corrupt) begin
            a4 = 16'hAAAA; b4 = 16'h5555; cin4 = ~cin; in_valid4 = 1'b1;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid4 && lat < 50);
        in_valid4 = 1'b0;
        checkOutput("d4_latency", lat, 32'd4);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                checkOutput("d4_hold_sum", {16'd0, s4}, {16'd0, es});
                checkOutput("d4_hold_carry", {31'd0, c4}, {31'd0, ec});
                checkOutput("d4_hold_valid", {31'd0, out_valid4}, 32'd1);
                checkOutput("d4_hold_in_ready", {31'd0, in_ready4}, 32'd0);
            end
            out_ready4 = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("d4_valid_after_handoff", {31'd0, out_valid4}, 32'd0);
        checkOutput("d4_idle_after_handoff", {31'd0, in_ready4}, 32'd1);
    endtask

    // One operation on the single-digit instance.
    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   input logic [15:0] es, input logic ec, input logic ev);
        int lat;
        exp_t e;
        e.s = es; e.c = ec; e.v = ev;
        sb16.push_back(e);
        out_ready16 = 1'b1;
        a16 = a; b16 = b; cin16 = cin; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid16 && lat < 50);
        checkOutput("d16_latency", lat, 32'd1);
        @(posedge clk); #1;
        checkOutput("d16_idle_after_handoff", {31'd0, in_ready16}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'd0, in_ready4}, 32'd0);
        checkOutput("reset_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("reset_sum", {16'd0, s4}, 32'd0);
        checkOutput("reset_carry", {31'd0, c4}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", {31'd0, in_ready4}, 32'd1);

        $display("[TB] carry out of all digits");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        $display("[TB] operand isolation during RUN");
        applyStimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1, 0);
        $display("[TB] backpressure in DONE");
        applyStimulus(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 3);
        $display("[TB] all ones with carry in");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        $display("[TB] signed overflow cases");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);

        $display("[TB] reset in the middle of RUN");
        out_ready4 = 1'b1;
        a4 = 16'h0F0F; b4 = 16'h0101; cin4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_out_valid", {31'd0, out_valid4}, 32'd0);
        checkOutput("abort_sum", {16'd0, s4}, 32'd0);
        checkOutput("abort_carry", {31'd0, c4}, 32'd0);
        checkOutput("abort_in_ready_in_reset", {31'd0, in_ready4}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_valid_pulse", {31'd0, out_valid4}, 32'd0);
        end
        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] single-digit instance");
        applyStimulus16(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        applyStimulus16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("d4_queue_drained", sb4.size(), 32'd0);
        checkOutput("d16_queue_drained", sb16.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
